// File: rtl/ag_video_fetch_if.sv
// Video RAM read port and pixel-shifter handshake bundle for ag_video_fetch.
// The fetcher uses the master modport; the RAM and shifter side uses slave.
interface ag_video_fetch_if;
    logic [13:0] ram_ab;
    logic        ram_cs;
    logic [15:0] ram_do;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready;

    modport master (output ram_ab, ram_cs, px_data, px_valid, input ram_do, px_ready);
    modport slave  (input ram_ab, ram_cs, px_data, px_valid, output ram_do, px_ready);
endinterface

// File: rtl/ag_video_fetch.sv
// Video port fetch sequencer: issues line reads to the 16K x 16 video RAM and
// buffers returned words in a 4-entry prefetch FIFO for the pixel shifter.
module ag_video_fetch #(
    parameter int WORDS_PER_LINE = 32,
    parameter int LINES          = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [13:0]      base,
    input  logic             frame_start,
    input  logic             line_start,
    ag_video_fetch_if.master bus,
    output logic             line_err,
    output logic             underrun,
    output logic             frame_done
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LINE = 2'd1,
        FETCH     = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    localparam logic [7:0]  WPL8   = 8'(WORDS_PER_LINE);
    localparam logic [13:0] WPL14  = 14'(WORDS_PER_LINE);
    localparam logic [8:0]  LINES9 = 9'(LINES);

    state_t      state_r;
    logic [13:0] line_base_r;
    logic [8:0]  line_r;
    logic [13:0] addr_r;
    logic [7:0]  issued_r;
    logic [13:0] ram_ab_r;
    logic        ram_cs_r;
    logic        pend_r;
    logic        line_err_r;
    logic        underrun_r;
    logic        frame_done_r;
    logic        starve_q_r;
    logic [15:0] mem_r [4];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  count_r;

    logic [3:0]  outstanding_s;
    logic        room_s;
    logic [13:0] next_base_s;
    logic [8:0]  next_line_s;
    logic        last_line_s;
    logic        flush_s;
    logic        push_s;
    logic        pop_s;
    logic        starve_s;

    // Words already buffered plus reads still on the RAM pipe (presented and returning).
    assign outstanding_s = {1'b0, count_r} + {3'b000, ram_cs_r} + {3'b000, pend_r};
    assign room_s        = outstanding_s < 4'd4;
    assign next_base_s   = line_base_r + WPL14;
    assign next_line_s   = line_r + 9'd1;
    assign last_line_s   = next_line_s == LINES9;
    assign flush_s       = !en || frame_start || (line_start && state_r != IDLE);
    assign push_s        = pend_r && !flush_s;
    assign pop_s         = (count_r != 3'd0) && bus.px_ready && !flush_s;
    assign starve_s      = bus.px_ready && (count_r == 3'd0) &&
                           ((state_r == FETCH) || (state_r == DRAIN && (ram_cs_r || pend_r)));

    assign bus.ram_ab   = ram_ab_r;
    assign bus.ram_cs   = ram_cs_r;
    assign bus.px_data  = mem_r[rd_ptr_r];
    assign bus.px_valid = count_r != 3'd0;
    assign line_err     = line_err_r;
    assign underrun     = underrun_r;
    assign frame_done   = frame_done_r;

    // Prefetch FIFO storage and pointers; a flush drops contents and the returning word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else if (flush_s) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.ram_do;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
        end
    end

    // Fetch sequencer: line/frame stepping, RAM read issue and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            line_base_r  <= 14'h0000;
            line_r       <= 9'd0;
            addr_r       <= 14'h0000;
            issued_r     <= 8'd0;
            ram_ab_r     <= 14'h0000;
            ram_cs_r     <= 1'b0;
            pend_r       <= 1'b0;
            line_err_r   <= 1'b0;
            underrun_r   <= 1'b0;
            frame_done_r <= 1'b0;
            starve_q_r   <= 1'b0;
        end else begin
            ram_cs_r     <= 1'b0;
            pend_r       <= ram_cs_r;
            line_err_r   <= 1'b0;
            frame_done_r <= 1'b0;
            // Underrun marks the onset of starvation so each episode gives one pulse.
            starve_q_r   <= starve_s;
            underrun_r   <= starve_s && !starve_q_r;
            if (!en) begin
                state_r    <= IDLE;
                pend_r     <= 1'b0;
                starve_q_r <= 1'b0;
                underrun_r <= 1'b0;
            end else if (frame_start) begin
                line_base_r <= base;
                line_r      <= 9'd0;
                pend_r      <= 1'b0;
                state_r     <= WAIT_LINE;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    WAIT_LINE: begin
                        if (line_start) begin
                            ram_cs_r <= 1'b1;
                            ram_ab_r <= line_base_r;
                            addr_r   <= line_base_r + 14'd1;
                            issued_r <= 8'd1;
                            pend_r   <= 1'b0;
                            state_r  <= (WPL8 == 8'd1) ? DRAIN : FETCH;
                        end
                    end
                    FETCH, DRAIN: begin
                        if (line_start) begin
                            line_err_r  <= 1'b1;
                            pend_r      <= 1'b0;
                            line_base_r <= next_base_s;
                            line_r      <= next_line_s;
                            addr_r      <= next_base_s;
                            issued_r    <= 8'd0;
                            state_r     <= last_line_s ? IDLE : FETCH;
                        end else if (state_r == FETCH) begin
                            if (room_s) begin
                                ram_cs_r <= 1'b1;
                                ram_ab_r <= addr_r;
                                addr_r   <= addr_r + 14'd1;
                                issued_r <= issued_r + 8'd1;
                                if (issued_r + 8'd1 == WPL8) begin
                                    state_r <= DRAIN;
                                end
                            end
                        end else if (!ram_cs_r && !pend_r) begin
                            line_base_r <= next_base_s;
                            line_r      <= next_line_s;
                            if (last_line_s) begin
                                frame_done_r <= 1'b1;
                                state_r      <= IDLE;
                            end else begin
                                state_r <= WAIT_LINE;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/ag_video_fetch.md
# ag_video_fetch

Fetch sequencer for the video port of the 32K×8 / 16K×16 dual-port video RAM. It generates the 14-bit word address and chip select for the synchronous 16-bit video read port. Fetched words land in a 4-entry prefetch FIFO, and a ready/valid handshake hands them to the pixel shifter. Line and frame sequencing follow timing pulses from the display timing generator; the frame base address comes from the mode register.

## Interface
- WORDS_PER_LINE, default 32: 16-bit words fetched per display line (1..255).
- LINES, default 256: active lines per frame (1..511).
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  fetch enable; low forces IDLE, flushes FIFO, RAM_CS=0.
- BASE  in  14  frame base word address; sampled only on FRAME_START.
- FRAME_START  in  1  one-cycle pulse, start of frame.
- LINE_START  in  1  one-cycle pulse, start of active line.
- RAM_AB  out  14  video port word address.
- RAM_CS  out  1  video port read enable.
- RAM_DO  in  16  video port data; valid the cycle after RAM_CS=1.
- PX_DATA  out  16  FIFO head word.
- PX_VALID  out  1  FIFO non-empty.
- PX_READY  in  1  shifter accepts PX_DATA when PX_VALID & PX_READY.
- LINE_ERR  out  1  one-cycle pulse: LINE_START arrived before current line finished fetching.
- UNDERRUN  out  1  one-cycle pulse: PX_READY=1, PX_VALID=0 while line words still owed.
- FRAME_DONE  out  1  one-cycle pulse after last word of last line is written to FIFO.

## Operation
- States: IDLE, WAIT_LINE, FETCH, DRAIN.
- IDLE: RAM_CS=0. FRAME_START & EN -> line_base<=BASE, line<=0, WAIT_LINE.
- WAIT_LINE: LINE_START -> addr<=line_base, issued<=0, FIFO flushed, FETCH.
- FETCH: issue a read (RAM_CS=1, RAM_AB=addr) whenever count+inflight<4; on issue addr<=addr+1 (14-bit wrap 3FFF->0000), issued++. When issued reaches WORDS_PER_LINE -> DRAIN.
- DRAIN: RAM_CS=0; when inflight=0: line_base<=line_base+WORDS_PER_LINE (14-bit wrap), line++; line==LINES -> pulse FRAME_DONE, IDLE; else WAIT_LINE.
- Write side: inflight read returns next cycle; RAM_DO pushed into FIFO that cycle. Space reservation guarantees no overflow.
- Pop: PX_VALID & PX_READY removes head. Simultaneous push and pop keep count unchanged.
- LINE_START in FETCH/DRAIN: pulse LINE_ERR, abandon line (in-flight return discarded, FIFO flushed), line_base+=WORDS_PER_LINE, line++. If line becomes LINES -> IDLE (no FRAME_DONE); else restart FETCH for next line in the following cycle.
- FRAME_START in any state except with EN=0: resamples BASE, line<=0, flush, WAIT_LINE; priority over same-cycle LINE_START (LINE_START ignored).
- EN falling: next cycle IDLE, FIFO empty, in-flight data discarded.
- UNDERRUN only evaluated in FETCH/DRAIN, and in WAIT_LINE never.

## Timing
- Reset values: RAM_AB=0, RAM_CS=0, PX_DATA=0, PX_VALID=0, LINE_ERR=0, UNDERRUN=0, FRAME_DONE=0; state IDLE, counters 0.
- RAM_AB/RAM_CS registered. First RAM_CS the cycle after LINE_START is registered (LINE_START at cycle n -> RAM_CS=1 at n+1 -> word in FIFO and PX_VALID=1 at n+3).
- Sustained throughput: 1 word/cycle with PX_READY held high; with PX_READY low, at most 4 issues, then RAM_CS=0.
- PX_DATA/PX_VALID driven from registers (FIFO head), no combinational path from RAM_DO.
- All pulse outputs exactly one cycle wide.

## Test plan
- Basic line: BASE=14'h0100, WORDS_PER_LINE=4, PX_READY=1, FRAME_START then LINE_START -> RAM_AB 0100..0103 on 4 consecutive cycles, 4 words out in order, no errors.
- Backpressure: PX_READY=0 after LINE_START -> exactly 4 RAM_CS cycles, then RAM_CS=0, PX_VALID=1; release -> remaining words issue, order preserved.
- Wrap: BASE=14'h3FFE, 4 words -> addresses 3FFE,3FFF,0000,0001; second line starts at 0002.
- Early LINE_START: second LINE_START 2 cycles into a 32-word line -> LINE_ERR pulse, FIFO flushed, next fetch at line_base+32.
- Frame end: LINES=2 -> FRAME_DONE pulse after line 2's last word; further LINE_START ignored until FRAME_START.
- Async reset mid-FETCH: RST asserted between clocks -> RAM_CS=0, PX_VALID=0 immediately; after release no activity until FRAME_START.
